// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: byte-level UART command responder that reads and writes an
// 8-bit register bus and answers with a status byte plus optional read data.
// Build option: define UART_BRIDGE_CHECKSUM_EN to require a trailing XOR
// checksum byte on every request frame.
module uart_reg_bridge #(
  parameter int unsigned BUS_TIMEOUT   = 255,
  parameter int unsigned FRAME_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       reg_req,
  output logic       reg_we,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  input  logic       reg_ack,
  output logic       busy,
  output logic       overrun
);

  localparam logic [7:0]  CMD_WRITE   = 8'h57;
  localparam logic [7:0]  CMD_READ    = 8'h52;
  localparam logic [7:0]  RSP_OK      = 8'h4B;
  localparam logic [7:0]  RSP_ERR     = 8'h45;
  localparam logic [15:0] BUS_LIMIT   = 16'(BUS_TIMEOUT);
  localparam logic [15:0] FRAME_LIMIT = 16'(FRAME_TIMEOUT);
  localparam logic [15:0] CNT_MAX     = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
`ifdef UART_BRIDGE_CHECKSUM_EN
    GET_CSUM,
`endif
    BUS,
    SEND_STAT,
    SEND_DATA
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  status_q;
  logic [7:0]  rdata_q;
  logic [15:0] frame_cnt;
  logic [15:0] bus_cnt;
  logic        in_get;
  logic        frame_expired;
  logic        bus_expired;
  logic        dropping;
  logic        cmd_ok;
`ifdef UART_BRIDGE_CHECKSUM_EN
  logic [7:0]  csum;
`endif

`ifdef UART_BRIDGE_CHECKSUM_EN
  assign in_get = (state == GET_ADDR) || (state == GET_DATA) || (state == GET_CSUM);
`else
  assign in_get = (state == GET_ADDR) || (state == GET_DATA);
`endif
  assign frame_expired = (frame_cnt == FRAME_LIMIT);
  assign bus_expired   = (bus_cnt == BUS_LIMIT);
  assign dropping      = rx_valid && ((state == BUS) || (state == SEND_STAT) || (state == SEND_DATA));
  assign cmd_ok        = !rx_error && ((rx_data == CMD_WRITE) || (rx_data == CMD_READ));

  // State register; reset abandons any frame or bus access in progress.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode: frame parsing, bus wait and response handshakes.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (rx_valid) next_state = cmd_ok ? GET_ADDR : SEND_STAT;
      end
      GET_ADDR: begin
        if (rx_valid) begin
          if (rx_error)    next_state = SEND_STAT;
          else if (reg_we) next_state = GET_DATA;
`ifdef UART_BRIDGE_CHECKSUM_EN
          else             next_state = GET_CSUM;
`else
          else             next_state = BUS;
`endif
        end else if (frame_expired) begin
          next_state = IDLE;
        end
      end
      GET_DATA: begin
        if (rx_valid) begin
`ifdef UART_BRIDGE_CHECKSUM_EN
          next_state = rx_error ? SEND_STAT : GET_CSUM;
`else
          next_state = rx_error ? SEND_STAT : BUS;
`endif
        end else if (frame_expired) begin
          next_state = IDLE;
        end
      end
`ifdef UART_BRIDGE_CHECKSUM_EN
      GET_CSUM: begin
        if (rx_valid)           next_state = (rx_error || (rx_data != csum)) ? SEND_STAT : BUS;
        else if (frame_expired) next_state = IDLE;
      end
`endif
      BUS: begin
        if (reg_ack || bus_expired) next_state = SEND_STAT;
      end
      SEND_STAT: begin
        if (tx_ready) next_state = ((status_q == RSP_OK) && !reg_we) ? SEND_DATA : IDLE;
      end
      SEND_DATA: begin
        if (tx_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: latch frame fields, capture read data and status, run the
  // saturating frame and bus wait counters, and flag dropped bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_we    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      rdata_q   <= 8'h00;
      status_q  <= 8'h00;
      frame_cnt <= 16'h0000;
      bus_cnt   <= 16'h0000;
      overrun   <= 1'b0;
`ifdef UART_BRIDGE_CHECKSUM_EN
      csum      <= 8'h00;
`endif
    end else begin
      overrun <= dropping;
      if ((state == IDLE) && rx_valid && cmd_ok)           reg_we    <= (rx_data == CMD_WRITE);
      if ((state == GET_ADDR) && rx_valid && !rx_error)    reg_addr  <= rx_data;
      if ((state == GET_DATA) && rx_valid && !rx_error)    reg_wdata <= rx_data;
      if ((state == BUS) && reg_ack)                       rdata_q   <= reg_rdata;
      if ((next_state == SEND_STAT) && (state != SEND_STAT))
        status_q <= ((state == BUS) && reg_ack) ? RSP_OK : RSP_ERR;
      if (!in_get || rx_valid)     frame_cnt <= 16'h0000;
      else if (frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + 16'h0001;
      if (state != BUS)            bus_cnt <= 16'h0000;
      else if (bus_cnt != CNT_MAX) bus_cnt <= bus_cnt + 16'h0001;
`ifdef UART_BRIDGE_CHECKSUM_EN
      if (state == IDLE)             csum <= rx_data;
      else if (in_get && rx_valid)   csum <= csum ^ rx_data;
`endif
    end
  end

  // Outputs decoded from state: bus request, response byte and busy flag.
  always_comb begin
    busy     = (state != IDLE);
    reg_req  = (state == BUS);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
      SEND_STAT: begin
        tx_valid = 1'b1;
        tx_data  = status_q;
      end
      SEND_DATA: begin
        tx_valid = 1'b1;
        tx_data  = rdata_q;
      end
      default: ;
    endcase
  end

endmodule
